// File: rtl/instr_pkg.sv
// Shared flit layout and collective opcode constants for the instruction path.
package instr_pkg;

  localparam int unsigned FlitWidth      = 82;
  localparam int unsigned PayloadWidth   = 32;
  localparam int unsigned ValidBitPos    = 81;
  localparam int unsigned OpPos          = 76;
  localparam int unsigned OpWidth        = 5;
  localparam int unsigned AlgTypePos     = 72;
  localparam int unsigned AlgTypeWidth   = 4;
  localparam int unsigned TagPos         = 64;
  localparam int unsigned TagWidth       = 8;
  localparam int unsigned ContextIdPos   = 56;
  localparam int unsigned ContextIdWidth = 8;
  localparam int unsigned RankPos        = 48;
  localparam int unsigned RankWidth      = 8;
  localparam int unsigned SrcPos         = 40;
  localparam int unsigned SrcWidth       = 8;
  localparam int unsigned DstPos         = 32;
  localparam int unsigned DstWidth       = 8;

  typedef enum logic [OpWidth-1:0] {
    OP_NOP            = 5'd0,
    OP_ALLREDUCE      = 5'd1,
    OP_REDUCE         = 5'd2,
    OP_BCAST          = 5'd3,
    OP_ALLGATHER      = 5'd4,
    OP_REDUCE_SCATTER = 5'd5,
    OP_ALLTOALL       = 5'd6,
    OP_BARRIER        = 5'd7
  } op_e;

  typedef struct packed {
    logic                      valid;
    op_e                       op;
    logic [AlgTypeWidth-1:0]   alg_type;
    logic [TagWidth-1:0]       tag;
    logic [ContextIdWidth-1:0] context_id;
    logic [RankWidth-1:0]      rank;
    logic [SrcWidth-1:0]       src;
    logic [DstWidth-1:0]       dst;
    logic [PayloadWidth-1:0]   payload;
  } flit_t;

endpackage

// File: rtl/instr_vc_fifo_if.sv
// Write/read/status bundle between the ingress, the channel FIFO and the engines.
interface instr_vc_fifo_if #(
  parameter int unsigned FLIT_W   = 82,
  parameter int unsigned LG_DEPTH = 4,
  parameter int unsigned LG_CH    = 2
);
  localparam int unsigned NumCh = 1 << LG_CH;
  localparam int unsigned CntW  = LG_DEPTH + 1;

  logic                    wr_en;
  logic [LG_CH-1:0]        wr_ch;
  logic [FLIT_W-1:0]       wr_data;
  logic                    rd_en;
  logic [LG_CH-1:0]        rd_ch;
  logic [FLIT_W-1:0]       rd_data;
  logic                    rd_valid;
  logic [NumCh-1:0]        empty;
  logic [NumCh-1:0]        full;
  logic [NumCh-1:0]        almost_full;
  logic [NumCh-1:0]        almost_empty;
  logic [NumCh*CntW-1:0]   count;
  logic                    ovf_err;
  logic                    udf_err;
  logic                    clear_err;

  modport master (
    output wr_en, wr_ch, wr_data, rd_en, rd_ch, clear_err,
    input  rd_data, rd_valid, empty, full, almost_full, almost_empty, count, ovf_err, udf_err
  );

  modport slave (
    input  wr_en, wr_ch, wr_data, rd_en, rd_ch, clear_err,
    output rd_data, rd_valid, empty, full, almost_full, almost_empty, count, ovf_err, udf_err
  );
endinterface

// File: rtl/instr_vc_fifo_vc_queue_ctrl.sv
// One channel's pointers, occupancy, status flags and accept decisions.
module vc_queue_ctrl #(
  parameter int unsigned LG_DEPTH  = 4,
  parameter int unsigned AF_THRESH = 14,
  parameter int unsigned AE_THRESH = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_req,
  input  logic                rd_req,
  output logic [LG_DEPTH-1:0] wr_ptr,
  output logic [LG_DEPTH-1:0] rd_ptr,
  output logic [LG_DEPTH:0]   count,
  output logic                empty_c,
  output logic                full_c,
  output logic                almost_full_c,
  output logic                almost_empty_c,
  output logic                wr_accept_c,
  output logic                rd_accept_c
);
  localparam int unsigned Depth = 1 << LG_DEPTH;
  localparam int unsigned CntW  = LG_DEPTH + 1;

  // Flags come from the registered count only, so no write-to-read bypass.
  assign empty_c        = (count == '0);
  assign full_c         = (count == CntW'(Depth));
  assign almost_full_c  = (count >= CntW'(AF_THRESH));
  assign almost_empty_c = (count <= CntW'(AE_THRESH));
  assign wr_accept_c    = wr_req && !full_c;
  assign rd_accept_c    = rd_req && !empty_c;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_accept_c) wr_ptr <= wr_ptr + LG_DEPTH'(1);
      if (rd_accept_c) rd_ptr <= rd_ptr + LG_DEPTH'(1);
      if (wr_accept_c && !rd_accept_c) begin
        count <= count + CntW'(1);
      end else if (rd_accept_c && !wr_accept_c) begin
        count <= count - CntW'(1);
      end
    end
  end

endmodule

// File: rtl/instr_vc_fifo.sv
// Multi-channel instruction FIFO: NUM_CH queues sharing one storage array,
// with a registered read port and sticky overflow/underflow reporting.
module instr_vc_fifo
  import instr_pkg::*;
#(
  parameter int unsigned FLIT_W    = FlitWidth,
  parameter int unsigned PAYLOAD_W = PayloadWidth,
  parameter int unsigned LG_DEPTH  = 4,
  parameter int unsigned LG_CH     = 2,
  parameter int unsigned AF_THRESH = (1 << LG_DEPTH) - 2,
  parameter int unsigned AE_THRESH = 1,
  parameter int unsigned DROP_NULL = 1
) (
  input logic                 clk,
  input logic                 rst,
  instr_vc_fifo_if.slave      bus
);
  localparam int unsigned NumCh = 1 << LG_CH;
  localparam int unsigned Depth = 1 << LG_DEPTH;
  localparam int unsigned CntW  = LG_DEPTH + 1;
  localparam int unsigned AddrW = LG_CH + LG_DEPTH;

  logic [FLIT_W-1:0]   mem [NumCh*Depth];
  logic [LG_DEPTH-1:0] wr_ptr [NumCh];
  logic [LG_DEPTH-1:0] rd_ptr [NumCh];
  logic [NumCh-1:0]    wr_acc_c;
  logic [NumCh-1:0]    rd_acc_c;
  logic                null_c;
  logic                wr_fire_c;
  logic                rd_fire_c;
  logic                ovf_set_c;
  logic                udf_set_c;
  logic [AddrW-1:0]    wr_addr_c;
  logic [AddrW-1:0]    rd_addr_c;

  // Null flits are swallowed before they reach any channel or error logic.
  assign null_c = (DROP_NULL != 0) && (bus.wr_data[PAYLOAD_W-1:0] == '0);

  for (genvar c = 0; c < NumCh; c++) begin : g_ch
    vc_queue_ctrl #(
      .LG_DEPTH  (LG_DEPTH),
      .AF_THRESH (AF_THRESH),
      .AE_THRESH (AE_THRESH)
    ) u_ctrl (
      .clk            (clk),
      .rst            (rst),
      .wr_req         (bus.wr_en && !null_c && (bus.wr_ch == LG_CH'(c))),
      .rd_req         (bus.rd_en && (bus.rd_ch == LG_CH'(c))),
      .wr_ptr         (wr_ptr[c]),
      .rd_ptr         (rd_ptr[c]),
      .count          (bus.count[c*CntW +: CntW]),
      .empty_c        (bus.empty[c]),
      .full_c         (bus.full[c]),
      .almost_full_c  (bus.almost_full[c]),
      .almost_empty_c (bus.almost_empty[c]),
      .wr_accept_c    (wr_acc_c[c]),
      .rd_accept_c    (rd_acc_c[c])
    );
  end

  assign wr_fire_c = |wr_acc_c;
  assign rd_fire_c = |rd_acc_c;
  assign wr_addr_c = {bus.wr_ch, wr_ptr[bus.wr_ch]};
  assign rd_addr_c = {bus.rd_ch, rd_ptr[bus.rd_ch]};
  assign ovf_set_c = bus.wr_en && !null_c && bus.full[bus.wr_ch];
  assign udf_set_c = bus.rd_en && bus.empty[bus.rd_ch];

  // Storage is intentionally not reset; pointers keep stale entries hidden.
  always_ff @(posedge clk) begin
    if (wr_fire_c) mem[wr_addr_c] <= bus.wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.rd_data  <= '0;
      bus.rd_valid <= 1'b0;
    end else begin
      bus.rd_valid <= rd_fire_c;
      if (rd_fire_c) bus.rd_data <= mem[rd_addr_c];
    end
  end

  // Sticky errors: a new error in the same cycle outranks clear_err.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.ovf_err <= 1'b0;
      bus.udf_err <= 1'b0;
    end else begin
      if (ovf_set_c)          bus.ovf_err <= 1'b1;
      else if (bus.clear_err) bus.ovf_err <= 1'b0;
      if (udf_set_c)          bus.udf_err <= 1'b1;
      else if (bus.clear_err) bus.udf_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_instr_vc_fifo.sv
// Scoreboard bench for instr_vc_fifo: per-channel queue model plus read-data monitor.
module tb_instr_vc_fifo;
  localparam int unsigned FW  = 82;
  localparam int unsigned PW  = 32;
  localparam int unsigned LGD = 2;
  localparam int unsigned LGC = 1;
  localparam int unsigned NCH = 2;
  localparam int unsigned DEP = 4;
  localparam int unsigned CW  = 3;
  localparam int unsigned AF  = 2;
  localparam int unsigned AE  = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  logic [FW-1:0] mq [NCH][$];
  logic [FW-1:0] exp_q [$];
  logic [FW-1:0] m_rd = '0;
  bit            m_ovf = 1'b0;
  bit            m_udf = 1'b0;
  logic [FW-1:0] mon_exp;

  instr_vc_fifo_if #(.FLIT_W(FW), .LG_DEPTH(LGD), .LG_CH(LGC)) bus ();
  instr_vc_fifo_if #(.FLIT_W(FW), .LG_DEPTH(LGD), .LG_CH(LGC)) bus_keep ();

  instr_vc_fifo #(
    .FLIT_W(FW), .PAYLOAD_W(PW), .LG_DEPTH(LGD), .LG_CH(LGC),
    .AF_THRESH(AF), .AE_THRESH(AE), .DROP_NULL(1)
  ) dut (.clk(clk), .rst(rst), .bus(bus));

  instr_vc_fifo #(
    .FLIT_W(FW), .PAYLOAD_W(PW), .LG_DEPTH(LGD), .LG_CH(LGC),
    .AF_THRESH(AF), .AE_THRESH(AE), .DROP_NULL(0)
  ) dut_keep (.clk(clk), .rst(rst), .bus(bus_keep));

  assign bus_keep.wr_en     = bus.wr_en;
  assign bus_keep.wr_ch     = bus.wr_ch;
  assign bus_keep.wr_data   = bus.wr_data;
  assign bus_keep.rd_en     = bus.rd_en;
  assign bus_keep.rd_ch     = bus.rd_ch;
  assign bus_keep.clear_err = bus.clear_err;

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [FW-1:0] mk(input logic [PW-1:0] p);
    logic [FW-1:0] f;
    f = '0;
    f[FW-1] = 1'b1;
    f[FW-2:PW] = (FW-1-PW)'({$urandom(), $urandom()});
    f[PW-1:0] = p;
    return f;
  endfunction

  task automatic check_status();
    for (int c = 0; c < NCH; c++) begin
      int n;
      n = mq[c].size();
      chk($sformatf("count%0d", c), FW'(bus.count[c*CW +: CW]), FW'(n));
      chk($sformatf("empty%0d", c), FW'(bus.empty[c]), FW'(n == 0));
      chk($sformatf("full%0d", c), FW'(bus.full[c]), FW'(n == DEP));
      chk($sformatf("afull%0d", c), FW'(bus.almost_full[c]), FW'(n >= AF));
      chk($sformatf("aempty%0d", c), FW'(bus.almost_empty[c]), FW'(n <= AE));
    end
    chk("ovf_err", FW'(bus.ovf_err), FW'(m_ovf));
    chk("udf_err", FW'(bus.udf_err), FW'(m_udf));
    chk("rd_data_hold", bus.rd_data, m_rd);
  endtask

  // One clock: drive, update the queue model at the edge, check status after.
  task automatic step(input bit r, input bit we, input int wch, input logic [FW-1:0] wd,
                      input bit re, input int rch, input bit ce);
    bit wnul, ovf_s, udf_s;
    rst           = r;
    bus.wr_en     = we;
    bus.wr_ch     = LGC'(wch);
    bus.wr_data   = wd;
    bus.rd_en     = re;
    bus.rd_ch     = LGC'(rch);
    bus.clear_err = ce;
    @(posedge clk);
    if (r) begin
      for (int c = 0; c < NCH; c++) mq[c].delete();
      m_rd  = '0;
      m_ovf = 1'b0;
      m_udf = 1'b0;
    end else begin
      wnul  = (wd[PW-1:0] == '0);
      ovf_s = we && !wnul && (mq[wch].size() == DEP);
      udf_s = re && (mq[rch].size() == 0);
      if (re && !udf_s) begin
        m_rd = mq[rch].pop_front();
        exp_q.push_back(m_rd);
      end
      if (we && !wnul && !ovf_s) mq[wch].push_back(wd);
      if (ovf_s) m_ovf = 1'b1; else if (ce) m_ovf = 1'b0;
      if (udf_s) m_udf = 1'b1; else if (ce) m_udf = 1'b0;
    end
    @(negedge clk);
    check_status();
  endtask

  task automatic wr(input int ch, input logic [PW-1:0] p);
    step(1'b0, 1'b1, ch, mk(p), 1'b0, 0, 1'b0);
  endtask

  task automatic rd(input int ch);
    step(1'b0, 1'b0, 0, '0, 1'b1, ch, 1'b0);
  endtask

  task automatic idle(input bit ce);
    step(1'b0, 1'b0, 0, '0, 1'b0, 0, ce);
  endtask

  always @(negedge clk) begin
    if (bus.rd_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("rd_valid_spurious", FW'(bus.rd_valid), FW'(0));
      end else begin
        mon_exp = exp_q.pop_front();
        chk("rd_data", bus.rd_data, mon_exp);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    bus.wr_en = 1'b0; bus.wr_ch = '0; bus.wr_data = '0;
    bus.rd_en = 1'b0; bus.rd_ch = '0; bus.clear_err = 1'b0;
    step(1'b1, 1'b0, 0, '0, 1'b0, 0, 1'b0);
    step(1'b1, 1'b0, 0, '0, 1'b0, 0, 1'b0);
    chk("rst_empty", FW'(bus.empty), FW'(2'b11));
    chk("rst_count", FW'(bus.count), FW'(0));
    chk("rst_rd_data", bus.rd_data, FW'(0));

    // Fill ch0, then overflow it.
    for (int i = 1; i <= 4; i++) wr(0, PW'(i));
    chk("fill_full0", FW'(bus.full[0]), FW'(1));
    chk("fill_count0", FW'(bus.count[0 +: CW]), FW'(4));
    wr(0, 32'd5);
    chk("ovf_set", FW'(bus.ovf_err), FW'(1));

    // Drain in order, then underflow.
    for (int i = 0; i < 4; i++) rd(0);
    rd(0);
    chk("udf_set", FW'(bus.udf_err), FW'(1));
    chk("udf_hold", FW'(bus.rd_data[PW-1:0]), FW'(4));
    idle(1'b1);

    // Interleaved channels.
    wr(0, 32'hA); wr(1, 32'hB); wr(0, 32'hC);
    rd(1); rd(0); rd(0);

    // Pointer wrap on ch1 with simultaneous read/write.
    wr(1, 32'd100);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 1, mk(PW'(200 + i)), 1'b1, 1, 1'b0);
    rd(1);

    // Null flit is dropped silently.
    wr(1, 32'd0);
    chk("null_count1", FW'(bus.count[CW +: CW]), FW'(0));
    chk("null_no_ovf", FW'(bus.ovf_err), FW'(0));

    // Same-channel rd+wr at full and at empty.
    for (int i = 0; i < 4; i++) wr(0, PW'(20 + i));
    step(1'b0, 1'b1, 0, mk(32'd9), 1'b1, 0, 1'b0);
    chk("fullrw_count0", FW'(bus.count[0 +: CW]), FW'(3));
    chk("fullrw_ovf", FW'(bus.ovf_err), FW'(1));
    idle(1'b1);
    step(1'b0, 1'b1, 1, mk(32'd7), 1'b1, 1, 1'b0);
    chk("emptyrw_count1", FW'(bus.count[CW +: CW]), FW'(1));
    chk("emptyrw_udf", FW'(bus.udf_err), FW'(1));
    rd(1);
    idle(1'b1);
    step(1'b0, 1'b0, 0, '0, 1'b1, 1, 1'b1);
    chk("set_beats_clear", FW'(bus.udf_err), FW'(1));
    for (int i = 0; i < 3; i++) rd(0);

    // Randomised traffic against the queue model.
    for (int i = 0; i < 300; i++) begin
      logic [PW-1:0] p;
      p = ($urandom_range(0, 7) == 0) ? '0 : PW'($urandom());
      step(1'b0, 1'($urandom_range(0, 1)), int'($urandom_range(0, 1)), mk(p),
           1'($urandom_range(0, 1)), int'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0));
    end
    idle(1'b0);

    // Reset mid-operation with a read in flight.
    step(1'b1, 1'b0, 0, '0, 1'b0, 0, 1'b0);
    wr(0, 32'd31); wr(0, 32'd32); wr(0, 32'd33);
    step(1'b1, 1'b0, 0, '0, 1'b1, 0, 1'b0);
    chk("rst_rd_valid", FW'(bus.rd_valid), FW'(0));
    chk("rst_counts", FW'(bus.count), FW'(0));
    chk("rst_rd_data2", bus.rd_data, FW'(0));

    // DROP_NULL=0 instance keeps the zero-payload flit.
    wr(1, 32'd0);
    chk("keepnull_count1", FW'(bus_keep.count[CW +: CW]), FW'(1));

    wr(0, 32'd55);
    rd(0);
    idle(1'b0);
    idle(1'b0);
    chk("scoreboard_left", FW'(exp_q.size()), FW'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
